// File: rtl/exec_arbiter.sv
// ---------------------------------------------------------------------------
// exec_arbiter
//   Two-port round-robin arbiter and sequencer for the shared execute ALU.
//   The winning request's operands are registered onto the ex_* outputs and
//   held there. The combinational ALU result is captured one cycle later and
//   returned over a response handshake tagged with the requester id.
//
// Ports
//   i_clk, i_rst_n            clock (rising edge), async active-low reset
//   i_req_valid / o_req_ready per-port request handshake (bit 0 = port 0)
//   i_req{0,1}_op/_src        opcode and source select per port
//   i_req{0,1}_rd1/_rd2/_ext  register operands and immediate per port
//   o_ex_alu_op/_alu_src      registered opcode / source select to execute
//   o_ex_rd1/_rd2/_ext        registered operands to execute
//   i_ex_res/_zero/_ofl       result and flags from execute
//   o_rsp_valid / i_rsp_ready response handshake
//   o_rsp_id                  port the response belongs to
//   o_rsp_res/_zero/_ofl      captured result and flags
// ---------------------------------------------------------------------------
module exec_arbiter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPW   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_req_valid,
    output logic [1:0]       o_req_ready,
    input  logic [OPW-1:0]   i_req0_op,
    input  logic [WIDTH-1:0] i_req0_rd1,
    input  logic [WIDTH-1:0] i_req0_rd2,
    input  logic [WIDTH-1:0] i_req0_ext,
    input  logic             i_req0_src,
    input  logic [OPW-1:0]   i_req1_op,
    input  logic [WIDTH-1:0] i_req1_rd1,
    input  logic [WIDTH-1:0] i_req1_rd2,
    input  logic [WIDTH-1:0] i_req1_ext,
    input  logic             i_req1_src,
    output logic [OPW-1:0]   o_ex_alu_op,
    output logic             o_ex_alu_src,
    output logic [WIDTH-1:0] o_ex_rd1,
    output logic [WIDTH-1:0] o_ex_rd2,
    output logic [WIDTH-1:0] o_ex_ext,
    input  logic [WIDTH-1:0] i_ex_res,
    input  logic             i_ex_zero,
    input  logic             i_ex_ofl,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_id,
    output logic [WIDTH-1:0] o_rsp_res,
    output logic             o_rsp_zero,
    output logic             o_rsp_ofl
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             r_last_grant;
    logic             r_ex_id;
    logic [OPW-1:0]   r_ex_alu_op;
    logic             r_ex_alu_src;
    logic [WIDTH-1:0] r_ex_rd1;
    logic [WIDTH-1:0] r_ex_rd2;
    logic [WIDTH-1:0] r_ex_ext;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_res;
    logic             r_rsp_zero;
    logic             r_rsp_ofl;

    logic             w_open;
    logic             w_accept;
    logic             w_grant_id;
    logic [OPW-1:0]   w_op;
    logic             w_src;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;
    logic [WIDTH-1:0] w_ext;

    // Arbitration and accept. Depends only on state, valids, last grant and
    // rsp_ready, never on the request payload.
    always_comb begin
        // A lone valid port wins; on contention the port not granted last wins.
        w_grant_id = (&i_req_valid) ? ~r_last_grant : i_req_valid[1];
        w_open     = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && i_rsp_ready);
        // Gating with reset keeps ready low while reset is held, since the
        // state register already reads IDLE during that time.
        w_accept   = i_rst_n && w_open && (|i_req_valid);
        o_req_ready = 2'b00;
        if (w_accept) begin
            o_req_ready = w_grant_id ? 2'b10 : 2'b01;
        end
    end

    // Winner's payload.
    always_comb begin
        w_op  = w_grant_id ? i_req1_op  : i_req0_op;
        w_src = w_grant_id ? i_req1_src : i_req0_src;
        w_rd1 = w_grant_id ? i_req1_rd1 : i_req0_rd1;
        w_rd2 = w_grant_id ? i_req1_rd2 : i_req0_rd2;
        w_ext = w_grant_id ? i_req1_ext : i_req0_ext;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                // Response consumed: chain straight into the next op if one
                // was accepted in the same cycle, otherwise go idle.
                if (i_rsp_ready) begin
                    w_state_next = w_accept ? ST_ISSUE : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_ex_id      <= 1'b0;
            r_ex_alu_op  <= '0;
            r_ex_alu_src <= 1'b0;
            r_ex_rd1     <= '0;
            r_ex_rd2     <= '0;
            r_ex_ext     <= '0;
            r_rsp_id     <= 1'b0;
            r_rsp_res    <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_ofl    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_last_grant <= w_grant_id;
                r_ex_id      <= w_grant_id;
                r_ex_alu_op  <= w_op;
                r_ex_alu_src <= w_src;
                r_ex_rd1     <= w_rd1;
                r_ex_rd2     <= w_rd2;
                r_ex_ext     <= w_ext;
            end
            // Execute has had the full ISSUE cycle to settle.
            if (r_state == ST_ISSUE) begin
                r_rsp_id   <= r_ex_id;
                r_rsp_res  <= i_ex_res;
                r_rsp_zero <= i_ex_zero;
                r_rsp_ofl  <= i_ex_ofl;
            end
        end
    end

    assign o_ex_alu_op  = r_ex_alu_op;
    assign o_ex_alu_src = r_ex_alu_src;
    assign o_ex_rd1     = r_ex_rd1;
    assign o_ex_rd2     = r_ex_rd2;
    assign o_ex_ext     = r_ex_ext;
    assign o_rsp_valid  = (r_state == ST_HOLD);
    assign o_rsp_id     = r_rsp_id;
    assign o_rsp_res    = r_rsp_res;
    assign o_rsp_zero   = r_rsp_zero;
    assign o_rsp_ofl    = r_rsp_ofl;

endmodule

// File: tb/tb_exec_arbiter.sv
// ---------------------------------------------------------------------------
// tb_exec_arbiter
//   Self-checking bench for exec_arbiter. A behavioural ALU stands in for the
//   execute stage. A transaction-level model (one op in execute, one response
//   waiting, last winner) predicts ready, response and execute-side values.
// ---------------------------------------------------------------------------
module tb_exec_arbiter;

    localparam int W  = 16;
    localparam int OW = 4;
    localparam int PW = OW + 1 + 3 * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req_valid = 2'b00;
    logic [1:0]    req_ready;
    logic [OW-1:0] op [2];
    logic          src [2];
    logic [W-1:0]  rd1 [2];
    logic [W-1:0]  rd2 [2];
    logic [W-1:0]  ext [2];
    logic [OW-1:0] ex_op;
    logic          ex_src;
    logic [W-1:0]  ex_rd1, ex_rd2, ex_ext;
    logic [W-1:0]  ex_res;
    logic          ex_zero, ex_ofl;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_id;
    logic [W-1:0]  rsp_res;
    logic          rsp_zero, rsp_ofl;
    logic [W+1:0]  alu_out;

    always #5 clk = ~clk;

    exec_arbiter #(.WIDTH(W), .OPW(OW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req0_op    (op[0]),
        .i_req0_rd1   (rd1[0]),
        .i_req0_rd2   (rd2[0]),
        .i_req0_ext   (ext[0]),
        .i_req0_src   (src[0]),
        .i_req1_op    (op[1]),
        .i_req1_rd1   (rd1[1]),
        .i_req1_rd2   (rd2[1]),
        .i_req1_ext   (ext[1]),
        .i_req1_src   (src[1]),
        .o_ex_alu_op  (ex_op),
        .o_ex_alu_src (ex_src),
        .o_ex_rd1     (ex_rd1),
        .o_ex_rd2     (ex_rd2),
        .o_ex_ext     (ex_ext),
        .i_ex_res     (ex_res),
        .i_ex_zero    (ex_zero),
        .i_ex_ofl     (ex_ofl),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_id     (rsp_id),
        .o_rsp_res    (rsp_res),
        .o_rsp_zero   (rsp_zero),
        .o_rsp_ofl    (rsp_ofl)
    );

    // Behavioural execute: 0 ADD, 1 SUB (operand2 - rd1), 2 AND, 3 OR, 4 XOR,
    // others pass rd1. Returns {ofl, zero, res}.
    function automatic logic [W+1:0] alu(input logic [OW-1:0] f, input logic s,
                                         input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] x);
        logic [W-1:0] y;
        logic [W-1:0] r;
        logic         o;
        y = s ? x : b;
        o = 1'b0;
        case (f)
            4'd0: begin
                r = a + y;
                o = (a[W-1] == y[W-1]) && (r[W-1] != a[W-1]);
            end
            4'd1: begin
                r = y - a;
                o = (y[W-1] != a[W-1]) && (r[W-1] != y[W-1]);
            end
            4'd2: r = a & y;
            4'd3: r = a | y;
            4'd4: r = a ^ y;
            default: r = a;
        endcase
        return {o, (r == '0), r};
    endfunction

    always_comb alu_out = alu(ex_op, ex_src, ex_rd1, ex_rd2, ex_ext);
    assign ex_res  = alu_out[W-1:0];
    assign ex_zero = alu_out[W];
    assign ex_ofl  = alu_out[W+1];

    int n_cmp = 0;
    int n_err = 0;

    // Model state.
    logic          m_busy = 1'b0;
    logic          m_hold = 1'b0;
    logic          m_last = 1'b1;
    logic          m_id = 1'b0;
    logic [PW-1:0] m_ex = '0;
    logic [W+1:0]  m_rsp = '0;
    logic          m_rsp_id = 1'b0;
    logic          acc_valid = 1'b0;
    logic          acc_port = 1'b0;
    logic [1:0]    obs_ready = 2'b00;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] payload(input int p);
        return {op[p], src[p], rd1[p], rd2[p], ext[p]};
    endfunction

    task automatic set_req(input int p, input logic [OW-1:0] f, input logic s,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] x);
        op[p] = f; src[p] = s; rd1[p] = a; rd2[p] = b; ext[p] = x;
    endtask

    task automatic rand_req(input int p);
        set_req(p, 4'($urandom_range(0, 5)), 1'($urandom), W'($urandom), W'($urandom),
                W'($urandom));
    endtask

    // One clock cycle: check outputs at the falling edge, advance the model at
    // the rising edge, return 1 time unit after it.
    task automatic step();
        logic       gv;
        logic       g;
        logic [1:0] exp_ready;
        @(negedge clk);
        gv = rst_n && !m_busy && (!m_hold || rsp_ready) && (req_valid != 2'b00);
        g  = (req_valid == 2'b10) || ((req_valid == 2'b11) && !m_last);
        exp_ready = gv ? (g ? 2'b10 : 2'b01) : 2'b00;
        obs_ready = req_ready;
        check("req_ready", req_ready, exp_ready);
        check("rsp_valid", rsp_valid, m_hold);
        if (m_hold) begin
            check("rsp_id", rsp_id, m_rsp_id);
            check("rsp_res", rsp_res, m_rsp[W-1:0]);
            check("rsp_zero", rsp_zero, m_rsp[W]);
            check("rsp_ofl", rsp_ofl, m_rsp[W+1]);
        end
        check("ex_bus", {ex_op, ex_src, ex_rd1, ex_rd2, ex_ext}, m_ex);
        @(posedge clk);
        if (m_busy) begin
            m_rsp = alu(m_ex[PW-1 -: OW], m_ex[3*W], m_ex[3*W-1 -: W], m_ex[2*W-1 -: W],
                        m_ex[W-1:0]);
            m_rsp_id = m_id;
            m_hold   = 1'b1;
            m_busy   = 1'b0;
        end else if (m_hold && rsp_ready) begin
            m_hold = 1'b0;
        end
        acc_valid = gv;
        acc_port  = g;
        if (gv) begin
            m_ex   = payload(int'(g));
            m_id   = g;
            m_busy = 1'b1;
            m_last = g;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp", {rsp_id, rsp_res, rsp_zero, rsp_ofl}, '0);
        check("rst_ex", {ex_op, ex_src, ex_rd1, ex_rd2, ex_ext}, '0);
        check("rst_req_ready", req_ready, 2'b00);
        m_busy = 1'b0; m_hold = 1'b0; m_last = 1'b1; m_ex = '0; m_rsp = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [1:0] grants [$];
        int         n_acc;

        set_req(0, '0, 1'b0, '0, '0, '0);
        set_req(1, '0, 1'b0, '0, '0, '0);
        req_valid = 2'b11;
        apply_reset();

        // Single request, SUB 5 - 3.
        req_valid = 2'b01; rsp_ready = 1'b1;
        set_req(0, 4'd1, 1'b0, 16'h0003, 16'h0005, 16'h0000);
        step();
        check("single_ready", obs_ready, 2'b01);
        req_valid = 2'b00;
        step();
        check("single_rsp_valid", rsp_valid, 1'b1);
        check("single_rsp_id", rsp_id, 1'b0);
        check("single_rsp_res", rsp_res, 16'h0002);
        check("single_rsp_zero", rsp_zero, 1'b0);
        drain(2);

        // Flags: overflow, then zero.
        req_valid = 2'b01;
        set_req(0, 4'd1, 1'b0, 16'h0001, 16'h8000, 16'h0000);
        step(); req_valid = 2'b00; step();
        check("flag_ofl", rsp_ofl, 1'b1);
        check("flag_ofl_res", rsp_res, 16'h7fff);
        req_valid = 2'b01;
        set_req(0, 4'd1, 1'b0, 16'h1234, 16'h1234, 16'h0000);
        step(); req_valid = 2'b00; step();
        check("flag_zero", rsp_zero, 1'b1);
        check("flag_zero_res", rsp_res, 16'h0000);
        drain(2);

        // Immediate source from port 1.
        req_valid = 2'b10;
        set_req(1, 4'd0, 1'b1, 16'h0005, 16'hffff, 16'h0010);
        step();
        check("imm_ex_src", ex_src, 1'b1);
        check("imm_ex_ext", ex_ext, 16'h0010);
        req_valid = 2'b00;
        step();
        check("imm_rsp_id", rsp_id, 1'b1);
        check("imm_rsp_res", rsp_res, 16'h0015);
        drain(2);

        // Backpressure with port 1 pending.
        rsp_ready = 1'b0; req_valid = 2'b01;
        set_req(0, 4'd3, 1'b0, 16'h00f0, 16'h0f00, 16'h0000);
        step(); req_valid = 2'b00; step();
        req_valid = 2'b10;
        set_req(1, 4'd2, 1'b0, 16'hff0f, 16'h0ff0, 16'h0000);
        for (int i = 0; i < 5; i++) step();
        check("bp_held_res", rsp_res, 16'h0ff0);
        rsp_ready = 1'b1;
        step();
        check("bp_release_ready", obs_ready, 2'b10);
        drain(3);

        // Contention: both valid, responses always consumed.
        req_valid = 2'b11;
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (obs_ready != 2'b00) begin
                grants.push_back(obs_ready);
                n_acc++;
            end
            if (acc_valid) rand_req(int'(acc_port));
        end
        check("cont_accepts", n_acc, 4);
        for (int i = 0; i < grants.size(); i++) begin
            check("cont_order", grants[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        end

        // Reset during ISSUE, then port 0 must win contention.
        drain(3);
        req_valid = 2'b11;
        step();
        apply_reset();
        step();
        check("post_reset_winner", obs_ready, 2'b01);
        drain(3);

        // Randomized traffic with payload held until accepted.
        for (int i = 0; i < 400; i++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
            for (int p = 0; p < 2; p++) begin
                if ((acc_valid && (int'(acc_port) == p)) || !req_valid[p]) begin
                    req_valid[p] = ($urandom_range(0, 2) != 0);
                    rand_req(p);
                end
            end
        end
        drain(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
